iob_sync_fifo_w_wide_r_narrow: RTL and testbench

//  Single-clock width-converting FIFO: wide words written, narrow words read out.

---
 rtl/iob_sync_fifo_w_wide_r_narrow.sv | 116 +++++++++++
 tb/tb_iob_sync_fifo_w_wide_r_narrow.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/iob_sync_fifo_w_wide_r_narrow.sv
// Single-clock FIFO: RATIO narrow slots are written per wide word, and narrow words are read out LSB slice first.
// Optional sticky overflow/underflow outputs are enabled by defining IOB_FIFO_ERR_FLAGS_EN.
module iob_sync_fifo_w_wide_r_narrow #(
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_empty,
    output logic [ADDR_W:0]     level
`ifdef IOB_FIFO_ERR_FLAGS_EN
    ,
    output logic                w_overflow,
    output logic                r_underflow
`endif
);

    localparam int unsigned RATIO     = W_DATA_W / R_DATA_W;
    localparam int unsigned LOG2RATIO = $clog2(RATIO);
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned WPTR_W    = (ADDR_W > LOG2RATIO) ? ADDR_W - LOG2RATIO : 1;
    localparam int unsigned LVL_W     = ADDR_W + 1;

    logic [R_DATA_W-1:0] r_mem [DEPTH];
    logic [WPTR_W-1:0]   r_w_ptr;
    logic [ADDR_W-1:0]   r_r_ptr;
    logic [LVL_W-1:0]    r_level;
    logic [R_DATA_W-1:0] r_rdata;
    logic                r_r_empty;
    logic                r_w_full;

    logic                w_wr_acc;
    logic                w_rd_acc;
    logic [LVL_W-1:0]    w_level_nxt;
    logic [ADDR_W-1:0]   w_w_base;

    // Accept decisions and next occupancy; flags are registered from this next level.
    always_comb begin
        w_wr_acc    = w_en && !r_w_full;
        w_rd_acc    = r_en && !r_r_empty;
        w_level_nxt = r_level;
        if (w_wr_acc) begin
            w_level_nxt = w_level_nxt + LVL_W'(RATIO);
        end
        if (w_rd_acc) begin
            w_level_nxt = w_level_nxt - LVL_W'(1);
        end
        w_w_base = ADDR_W'(r_w_ptr) << LOG2RATIO;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_ptr   <= '0;
            r_r_ptr   <= '0;
            r_level   <= '0;
            r_rdata   <= '0;
            r_r_empty <= 1'b1;
            r_w_full  <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_w_ptr <= r_w_ptr + WPTR_W'(1);
            end
            if (w_rd_acc) begin
                r_r_ptr <= r_r_ptr + ADDR_W'(1);
                r_rdata <= r_mem[r_r_ptr];
            end
            r_level   <= w_level_nxt;
            r_r_empty <= (w_level_nxt == LVL_W'(0));
            r_w_full  <= (w_level_nxt > LVL_W'(DEPTH - RATIO));
        end
    end

    // Storage is not reset; one wide write fills RATIO consecutive narrow slots.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                r_mem[w_w_base | ADDR_W'(i)] <= w_data[i*R_DATA_W +: R_DATA_W];
            end
        end
    end

    assign w_full  = r_w_full;
    assign r_empty = r_r_empty;
    assign r_data  = r_rdata;
    assign level   = r_level;

`ifdef IOB_FIFO_ERR_FLAGS_EN
    logic r_w_overflow;
    logic r_r_underflow;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_overflow  <= 1'b0;
            r_r_underflow <= 1'b0;
        end else begin
            if (w_en && r_w_full) begin
                r_w_overflow <= 1'b1;
            end
            if (r_en && r_r_empty) begin
                r_r_underflow <= 1'b1;
            end
        end
    end

    assign w_overflow  = r_w_overflow;
    assign r_underflow = r_r_underflow;
`endif

endmodule

// File: tb/tb_iob_sync_fifo_w_wide_r_narrow.sv
// Bench for iob_sync_fifo_w_wide_r_narrow (32->8, 16 bytes) against a byte-queue reference model.
// Also covers the IOB_FIFO_ERR_FLAGS_EN build when that macro is defined.
module tb_iob_sync_fifo_w_wide_r_narrow;

    localparam int unsigned W_DATA_W = 32;
    localparam int unsigned R_DATA_W = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned RATIO    = 4;

    logic                clk;
    logic                rst;
    logic                w_en;
    logic [W_DATA_W-1:0] w_data;
    logic                w_full;
    logic                r_en;
    logic [R_DATA_W-1:0] r_data;
    logic                r_empty;
    logic [ADDR_W:0]     level;
`ifdef IOB_FIFO_ERR_FLAGS_EN
    logic                w_overflow;
    logic                r_underflow;
`endif

    iob_sync_fifo_w_wide_r_narrow #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w_en    (w_en),
        .w_data  (w_data),
        .w_full  (w_full),
        .r_en    (r_en),
        .r_data  (r_data),
        .r_empty (r_empty),
        .level   (level)
`ifdef IOB_FIFO_ERR_FLAGS_EN
        ,
        .w_overflow  (w_overflow),
        .r_underflow (r_underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue of stored bytes, last byte read, sticky error flags.
    logic [7:0] q[$];
    logic [7:0] exp_rd;
    logic       exp_ovf;
    logic       exp_unf;

    int n_checks;
    int n_pass;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"},   32'(level),   32'(q.size()));
        chk({tag, ".r_empty"}, 32'(r_empty), 32'(q.size() == 0));
        chk({tag, ".w_full"},  32'(w_full),  32'(q.size() > DEPTH - RATIO));
        chk({tag, ".r_data"},  32'(r_data),  32'(exp_rd));
`ifdef IOB_FIFO_ERR_FLAGS_EN
        chk({tag, ".w_overflow"},  32'(w_overflow),  32'(exp_ovf));
        chk({tag, ".r_underflow"}, 32'(r_underflow), 32'(exp_unf));
`endif
    endtask

    // One clock with the given requests; model decides acceptance from its pre-edge occupancy.
    task automatic step(input string tag, input logic we, input logic re, input logic [31:0] d);
        int sz;
        sz     = q.size();
        w_en   = we;
        r_en   = re;
        w_data = d;
        @(posedge clk);
        #1;
        if (we && sz > int'(DEPTH - RATIO)) exp_ovf = 1'b1;
        if (re && sz == 0) exp_unf = 1'b1;
        if (re && sz > 0) exp_rd = q.pop_front();
        if (we && sz <= int'(DEPTH - RATIO)) begin
            for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
        end
        w_en = 1'b0;
        r_en = 1'b0;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        exp_rd  = 8'h00;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all(tag);
        #3;
        rst = 1'b0;
        step({tag, "_post"}, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) step(tag, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_rd   = 8'h00;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
        rst      = 1'b1;
        w_en     = 1'b0;
        r_en     = 1'b0;
        w_data   = '0;
        #12;
        check_all("reset");
        rst = 1'b0;
        step("idle", 1'b0, 1'b0, 32'h0);

        // Single word, byte order LSB first
        step("wr1", 1'b1, 1'b0, 32'h44332211);
        for (int i = 0; i < 4; i++) step("rd1", 1'b0, 1'b1, 32'h0);
        step("rd_empty", 1'b0, 1'b1, 32'h0);

        // Fill to full, extra write dropped, contents intact
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, $urandom);
        step("wr_full", 1'b1, 1'b0, 32'hDEADBEEF);
        drain("drain_full");

        // Full threshold at 13 vs 12
        for (int i = 0; i < 4; i++) step("fill2", 1'b1, 1'b0, $urandom);
        for (int i = 0; i < 3; i++) step("to13", 1'b0, 1'b1, 32'h0);
        step("wr_at13", 1'b1, 1'b0, $urandom);
        step("to12", 1'b0, 1'b1, 32'h0);
        step("wr_at12", 1'b1, 1'b0, $urandom);
        drain("drain_thr");

        // Simultaneous read and write at level 4 and at level 0
        step("wr4", 1'b1, 1'b0, $urandom);
        step("rw_at4", 1'b1, 1'b1, $urandom);
        drain("drain_rw");
        step("rw_at0", 1'b1, 1'b1, $urandom);
        drain("drain_rw0");

        // Mid-run asynchronous reset with data stored
        step("pre_rst", 1'b1, 1'b0, $urandom);
        step("pre_rst", 1'b1, 1'b1, $urandom);
        async_reset("rst_mid");

        // Random traffic with pointer wraps and another reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) async_reset("rst_rand");
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        drain("drain_end");
        step("rd_empty_end", 1'b0, 1'b1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
